// File: rtl/serial_word_tx_pkg.sv
// serial_word_tx_pkg: state encoding and counter sizing shared by the serial transmitter
package serial_word_tx_pkg;

    // FSM states, prefixed so they never collide with the GAP parameter
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } tx_state_e;

    localparam int GAP_CNT_W = 4;

    // Bit counter must hold WIDTH-1; never narrower than one bit
    function automatic int bit_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Gap counter reload value on entry to the gap state
    function automatic logic [GAP_CNT_W-1:0] gap_load(input int gap);
        return (gap > 0) ? GAP_CNT_W'(gap - 1) : '0;
    endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// tx_shift_reg: loadable shifter whose head bit is the registered serial output
module tx_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load wins over shift; zeros shift in so the line is low once a word has drained
    always_comb begin
        sr_d = load_i ? data_i :
               shift_i ? (MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]}) :
               sr_q;
    end

    // Shift register state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sr_q <= '0;
        else         sr_q <= sr_d;
    end

    assign bit_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel word in over valid/ready, serial bit stream out with idle gap
module serial_word_tx
    import serial_word_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic             ser_out_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = bit_cnt_w(WIDTH);

    tx_state_e            state_q;
    logic [CW-1:0]        bit_cnt_q;
    logic [GAP_CNT_W-1:0] gap_cnt_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 accept;

    assign accept = (state_q == ST_IDLE) && data_valid_i;

    tx_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (accept),
        .shift_i (state_q == ST_SHIFT),
        .data_i  (data_in_i),
        .bit_o   (ser_out_o)
    );

    // Control FSM with counters; status outputs are registered from the next state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (data_valid_i) begin
                        state_q   <= ST_SHIFT;
                        bit_cnt_q <= CW'(WIDTH - 1);
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    done_q <= (bit_cnt_q == CW'(1));
                    if (bit_cnt_q == '0) begin
                        state_q   <= (GAP > 0) ? ST_GAP : ST_IDLE;
                        gap_cnt_q <= gap_load(GAP);
                        ready_q   <= (GAP == 0);
                        busy_q    <= (GAP != 0);
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready_o = ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
